l2_access_arbiter: RTL and testbench

Sequences every access into the L2 cache. It shares the single L2 request port between demand traffic (L1 misses and writebacks) and prefetch installs. It sits between the L1 arbiter/prefetcher and the L2 cache: it drives the L2 address-select (`prefetch`) and `dont_prefetch` controls, holds one prefetched block, and guarantees demand priority with bounded prefetch starvation and no stale-install hazards.

---
 rtl/l2_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_l2_access_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_access_arbiter.sv
// l2_access_arbiter
// Sequences every access into the L2 cache. Demand traffic (L1 misses and
// writebacks) shares the single L2 request port with installs from a
// one-entry prefetch buffer. Demand normally wins, but a waiting install is
// forced once MAX_DEFER demand grants have gone past it. A demand read to
// the buffered block waits for the install. A demand write to the buffered
// block drops the now-stale prefetch.

module l2_access_arbiter #(
    parameter int unsigned MAX_DEFER = 4
) (
    input  logic         clk,
    input  logic         reset,
    // demand side (L1 arbiter)
    input  logic         dem_read,
    input  logic         dem_write,
    input  logic [15:0]  dem_address,
    input  logic [127:0] dem_wdata,
    output logic         dem_resp,
    output logic [127:0] dem_rdata,
    // prefetcher side
    input  logic         pf_valid,
    input  logic [15:0]  pf_address,
    input  logic [127:0] pf_rdata,
    output logic         pf_ack,
    output logic         dont_prefetch,
    // L2 side
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    output logic         l2_prefetch,
    input  logic         l2_resp,
    input  logic [127:0] l2_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEMAND  = 2'd1,
        INSTALL = 2'd2
    } state_e;

    localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);

    state_e         state_q, state_d;
    logic           buf_valid_q, buf_valid_d;
    logic [15:0]    buf_addr_q, buf_addr_d;
    logic [127:0]   buf_data_q, buf_data_d;
    logic [3:0]     dcnt_q, dcnt_d;

    logic           dem_req;
    logic           blk_hit;
    logic           drop_buf;
    logic           install_done;
    logic           defer_inc;

    assign dem_req = dem_read | dem_write;

    // A demand touches the buffered block (compared on block address only).
    assign blk_hit = buf_valid_q & (dem_address[15:4] == buf_addr_q[15:4]);

    // The entry only accepts a new block when it is empty. A block offered
    // in the cycle the entry drains is therefore taken one cycle later.
    assign pf_ack        = pf_valid & ~buf_valid_q & ~reset;
    assign dont_prefetch = buf_valid_q | (state_q == INSTALL);

    // L2 read data always flows straight back to the demand side.
    assign dem_rdata = l2_rdata;

    // Next-state decision and L2 request outputs for the current state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        drop_buf     = 1'b0;
        install_done = 1'b0;
        defer_inc    = 1'b0;
        dem_resp     = 1'b0;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_prefetch  = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (dem_read && blk_hit) begin
                    // Install first so the read sees the prefetched block.
                    state_d = INSTALL;
                end else if (dem_write && blk_hit) begin
                    // The write supersedes the buffered block; drop it.
                    state_d  = DEMAND;
                    drop_buf = 1'b1;
                end else if (dem_req && buf_valid_q && (dcnt_q == MAX_DEFER_C)) begin
                    // The prefetch has waited long enough; force it in.
                    state_d = INSTALL;
                end else if (dem_req) begin
                    state_d   = DEMAND;
                    defer_inc = buf_valid_q;
                end else if (buf_valid_q) begin
                    state_d = INSTALL;
                end
            end

            DEMAND: begin
                l2_read    = dem_read;
                l2_write   = dem_write;
                l2_address = dem_address;
                l2_wdata   = dem_wdata;
                dem_resp   = l2_resp;
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end

            INSTALL: begin
                l2_write    = 1'b1;
                l2_prefetch = 1'b1;
                l2_address  = buf_addr_q;
                l2_wdata    = buf_data_q;
                if (l2_resp) begin
                    state_d      = IDLE;
                    install_done = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Prefetch entry and defer counter updates.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        dcnt_d      = dcnt_q;

        // Draining and capturing never coincide: a drain needs a full entry,
        // a capture needs an empty one.
        if (drop_buf || install_done) begin
            buf_valid_d = 1'b0;
        end
        if (pf_ack) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = pf_address;
            buf_data_d  = pf_rdata;
        end

        if (install_done) begin
            dcnt_d = '0;
        end else if (defer_inc && (dcnt_q != MAX_DEFER_C)) begin
            dcnt_d = dcnt_q + 4'd1;
        end
    end

    // State, entry and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            // NOTE: the wide data store is reset along with the entry so the
            // whole buffer has a known value from the first cycle after reset.
            buf_data_q  <= '0;
            dcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            dcnt_q      <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Bench for l2_access_arbiter (MAX_DEFER = 2): a directed vector table, a
// hand-written reset-abort sequence, then randomized traffic checked against
// a transaction-level reference model and a golden memory image.

module tb_l2_access_arbiter;

    localparam int          MD       = 2;
    localparam logic [127:0] PF_DATA  = {32{4'hA}};
    localparam logic [127:0] DEM_DATA = {4{32'h1234_5678}};

    logic         clk = 1'b0;
    logic         reset;
    logic         dem_read, dem_write;
    logic [15:0]  dem_address;
    logic [127:0] dem_wdata;
    logic         dem_resp;
    logic [127:0] dem_rdata;
    logic         pf_valid;
    logic [15:0]  pf_address;
    logic [127:0] pf_rdata;
    logic         pf_ack, dont_prefetch;
    logic         l2_read, l2_write, l2_prefetch;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2_access_arbiter #(.MAX_DEFER(MD)) dut (
        .clk          (clk),
        .reset        (reset),
        .dem_read     (dem_read),
        .dem_write    (dem_write),
        .dem_address  (dem_address),
        .dem_wdata    (dem_wdata),
        .dem_resp     (dem_resp),
        .dem_rdata    (dem_rdata),
        .pf_valid     (pf_valid),
        .pf_address   (pf_address),
        .pf_rdata     (pf_rdata),
        .pf_ack       (pf_ack),
        .dont_prefetch(dont_prefetch),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_prefetch  (l2_prefetch),
        .l2_resp      (l2_resp),
        .l2_rdata     (l2_rdata)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One table row = one clock cycle: inputs, then expected outputs.
    // ctl = {dem_resp, pf_ack, dont_prefetch, l2_read, l2_write, l2_prefetch}
    typedef struct packed {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        pfv;
        logic [15:0] pfa;
        logic        resp;
        logic [5:0]  ctl;
        logic [15:0] eadr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic pfv,
                                input logic [15:0] pfa, input logic resp,
                                input logic [5:0] ctl, input logic [15:0] eadr);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.pfv = pfv;
        v.pfa = pfa; v.resp = resp; v.ctl = ctl; v.eadr = eadr;
        return v;
    endfunction

    localparam int NV = 46;
    vec_t tv [NV];

    // Reference model state: the L2 operation in flight, the buffered block,
    // and a golden image of what the L2 must hold.
    typedef enum int { OP_NONE, OP_DEMAND, OP_INSTALL } op_e;
    op_e          m_op;
    logic         m_bv;
    logic [15:0]  m_ba;
    logic [127:0] m_bd;
    int           m_dc;
    logic [127:0] gmem  [logic [11:0]];
    logic [127:0] l2mem [logic [11:0]];

    // Random drivers and L2 responder.
    logic         d_act, d_wr, p_act;
    logic [15:0]  d_addr, p_addr;
    logic [127:0] d_data, p_data;
    int           age, lat;
    logic         rst_now, strobe, hit;
    logic         e_ack, e_dnp, e_rd, e_wr, e_pf, e_dresp;
    logic [127:0] gexp;

    initial begin
        // ---------------- directed vector table ----------------
        tv[0]  = mk(1,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        tv[1]  = mk(1,0,0,16'h0000,1,16'h1230,0,6'b000000,16'h0000);
        tv[2]  = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        tv[3]  = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        tv[4]  = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // demand read 0x4020, L2 answers 3 cycles after l2_read rises
        tv[5]  = mk(0,1,0,16'h4020,0,16'h0000,0,6'b000000,16'h0000);
        tv[6]  = mk(0,1,0,16'h4020,0,16'h0000,0,6'b000100,16'h4020);
        tv[7]  = mk(0,1,0,16'h4020,0,16'h0000,0,6'b000100,16'h4020);
        tv[8]  = mk(0,1,0,16'h4020,0,16'h0000,0,6'b000100,16'h4020);
        tv[9]  = mk(0,1,0,16'h4020,0,16'h0000,1,6'b100100,16'h4020);
        tv[10] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // prefetch 0x1230 with no demand
        tv[11] = mk(0,0,0,16'h0000,1,16'h1230,0,6'b010000,16'h0000);
        tv[12] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b001000,16'h0000);
        tv[13] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b001011,16'h1230);
        tv[14] = mk(0,0,0,16'h0000,0,16'h0000,1,6'b001011,16'h1230);
        tv[15] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // forced install after MD demand grants
        tv[16] = mk(0,0,0,16'h0000,1,16'h1230,0,6'b010000,16'h0000);
        tv[17] = mk(0,1,0,16'h5000,0,16'h0000,0,6'b001000,16'h0000);
        tv[18] = mk(0,1,0,16'h5000,0,16'h0000,1,6'b101100,16'h5000);
        tv[19] = mk(0,1,0,16'h6000,0,16'h0000,0,6'b001000,16'h0000);
        tv[20] = mk(0,1,0,16'h6000,0,16'h0000,1,6'b101100,16'h6000);
        tv[21] = mk(0,1,0,16'h7000,0,16'h0000,0,6'b001000,16'h0000);
        tv[22] = mk(0,1,0,16'h7000,0,16'h0000,0,6'b001011,16'h1230);
        tv[23] = mk(0,1,0,16'h7000,0,16'h0000,1,6'b001011,16'h1230);
        tv[24] = mk(0,1,0,16'h7000,0,16'h0000,0,6'b000000,16'h0000);
        tv[25] = mk(0,1,0,16'h7000,0,16'h0000,1,6'b100100,16'h7000);
        tv[26] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // demand read to the buffered block: install goes first
        tv[27] = mk(0,0,0,16'h0000,1,16'h1230,0,6'b010000,16'h0000);
        tv[28] = mk(0,1,0,16'h1236,0,16'h0000,0,6'b001000,16'h0000);
        tv[29] = mk(0,1,0,16'h1236,0,16'h0000,1,6'b001011,16'h1230);
        tv[30] = mk(0,1,0,16'h1236,0,16'h0000,0,6'b000000,16'h0000);
        tv[31] = mk(0,1,0,16'h1236,0,16'h0000,1,6'b100100,16'h1236);
        tv[32] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // demand write to the buffered block drops it; a pf_valid offered
        // in the draining cycle is taken one cycle later
        tv[33] = mk(0,0,0,16'h0000,1,16'h1230,0,6'b010000,16'h0000);
        tv[34] = mk(0,0,1,16'h1238,1,16'h9990,0,6'b001000,16'h0000);
        tv[35] = mk(0,0,1,16'h1238,1,16'h9990,0,6'b010010,16'h1238);
        tv[36] = mk(0,0,1,16'h1238,0,16'h0000,1,6'b101010,16'h1238);
        tv[37] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b001000,16'h0000);
        tv[38] = mk(0,0,0,16'h0000,0,16'h0000,1,6'b001011,16'h9990);
        tv[39] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);
        // defer count restarts from zero after an install
        tv[40] = mk(0,0,0,16'h0000,1,16'h2220,0,6'b010000,16'h0000);
        tv[41] = mk(0,1,0,16'h5000,0,16'h0000,0,6'b001000,16'h0000);
        tv[42] = mk(0,1,0,16'h5000,0,16'h0000,1,6'b101100,16'h5000);
        tv[43] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b001000,16'h0000);
        tv[44] = mk(0,0,0,16'h0000,0,16'h0000,1,6'b001011,16'h2220);
        tv[45] = mk(0,0,0,16'h0000,0,16'h0000,0,6'b000000,16'h0000);

        reset = 1'b1; dem_read = 1'b0; dem_write = 1'b0; dem_address = '0;
        dem_wdata = DEM_DATA; pf_valid = 1'b0; pf_address = '0; pf_rdata = PF_DATA;
        l2_resp = 1'b0; l2_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset       = tv[i].rst;
            dem_read    = tv[i].rd;
            dem_write   = tv[i].wr;
            dem_address = tv[i].addr;
            pf_valid    = tv[i].pfv;
            pf_address  = tv[i].pfa;
            l2_resp     = tv[i].resp;
            l2_rdata    = {4{32'hC0DE_0000 + 32'(i)}};
            #1;
            check($sformatf("vec%0d_ctl", i),
                  128'({dem_resp, pf_ack, dont_prefetch, l2_read, l2_write, l2_prefetch}),
                  128'(tv[i].ctl));
            if (tv[i].ctl[2] || tv[i].ctl[1])
                check($sformatf("vec%0d_addr", i), 128'(l2_address), 128'(tv[i].eadr));
            if (tv[i].ctl[1])
                check($sformatf("vec%0d_wdata", i), l2_wdata, tv[i].ctl[0] ? PF_DATA : DEM_DATA);
            check($sformatf("vec%0d_rdata", i), dem_rdata, {4{32'hC0DE_0000 + 32'(i)}});
            @(posedge clk);
            #1;
        end

        // ---------------- reset in the middle of a demand ----------------
        dem_read = 1'b0; dem_write = 1'b0; l2_resp = 1'b0;
        pf_valid = 1'b1; pf_address = 16'h3330;
        #1; check("abort_pf_ack", 128'(pf_ack), 128'(1'b1));
        @(posedge clk); #1;
        pf_valid = 1'b0; dem_read = 1'b1; dem_address = 16'h4440;
        #1; check("abort_decide", 128'({dont_prefetch, l2_read}), 128'(2'b10));
        @(posedge clk); #1;
        #1; check("abort_req", 128'({l2_read, l2_address}), 128'({1'b1, 16'h4440}));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; dem_read = 1'b0;
        #1; check("abort_idle",
                  128'({dem_resp, pf_ack, dont_prefetch, l2_read, l2_write, l2_prefetch}), 128'(0));
        @(posedge clk); #1;
        #1; check("abort_no_install", 128'({dont_prefetch, l2_write}), 128'(0));
        @(posedge clk); #1;

        // ---------------- randomized traffic vs. reference model ----------------
        m_op = OP_NONE; m_bv = 1'b0; m_ba = '0; m_bd = '0; m_dc = 0;
        d_act = 1'b0; d_wr = 1'b0; d_addr = '0; d_data = '0;
        p_act = 1'b0; p_addr = '0; p_data = '0;
        age = 0; lat = 1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_now     = (cyc < 2) || ($urandom_range(0, 399) == 0);
            reset       = rst_now;
            dem_read    = d_act && !d_wr;
            dem_write   = d_act && d_wr;
            dem_address = d_addr;
            dem_wdata   = d_data;
            pf_valid    = p_act;
            pf_address  = p_addr;
            pf_rdata    = p_data;
            l2_resp     = 1'b0;
            #1;
            strobe   = l2_read || l2_write;
            l2_resp  = !rst_now && strobe && (age >= lat);
            l2_rdata = l2_read ? (l2mem.exists(l2_address[15:4]) ? l2mem[l2_address[15:4]] : '0)
                               : {$urandom, $urandom, $urandom, $urandom};
            #1;

            e_ack   = pf_valid && !m_bv && !rst_now;
            e_dnp   = m_bv || (m_op == OP_INSTALL);
            e_rd    = (m_op == OP_DEMAND) && dem_read;
            e_wr    = ((m_op == OP_DEMAND) && dem_write) || (m_op == OP_INSTALL);
            e_pf    = (m_op == OP_INSTALL);
            e_dresp = (m_op == OP_DEMAND) && l2_resp;

            check("rnd_ctl",
                  128'({dem_resp, pf_ack, dont_prefetch, l2_read, l2_write, l2_prefetch}),
                  128'({e_dresp, e_ack, e_dnp, e_rd, e_wr, e_pf}));
            if (e_rd || e_wr)
                check("rnd_addr", 128'(l2_address), 128'(e_pf ? m_ba : dem_address));
            if (e_wr)
                check("rnd_wdata", l2_wdata, e_pf ? m_bd : dem_wdata);
            check("rnd_rdata", dem_rdata, l2_rdata);
            if (e_dresp && dem_read) begin
                gexp = gmem.exists(dem_address[15:4]) ? gmem[dem_address[15:4]] : '0;
                check("rnd_coherent", dem_rdata, gexp);
            end

            // L2 storage as seen by the hardware.
            if (l2_resp && l2_write) l2mem[l2_address[15:4]] = l2_wdata;

            // Reference model: pick / retire L2 operations by the priority rules.
            if (rst_now) begin
                m_op = OP_NONE; m_bv = 1'b0; m_ba = '0; m_bd = '0; m_dc = 0;
            end else begin
                hit = m_bv && (dem_address[15:4] == m_ba[15:4]);
                case (m_op)
                    OP_NONE: begin
                        if (dem_read && hit) m_op = OP_INSTALL;
                        else if (dem_write && hit) begin m_op = OP_DEMAND; m_bv = 1'b0; end
                        else if ((dem_read || dem_write) && m_bv && m_dc == MD) m_op = OP_INSTALL;
                        else if (dem_read || dem_write) begin
                            m_op = OP_DEMAND;
                            if (m_bv) m_dc++;
                        end
                        else if (m_bv) m_op = OP_INSTALL;
                    end
                    OP_DEMAND: begin
                        if (l2_resp) begin
                            if (dem_write) gmem[dem_address[15:4]] = dem_wdata;
                            m_op = OP_NONE;
                        end
                    end
                    default: begin
                        if (l2_resp) begin
                            gmem[m_ba[15:4]] = m_bd;
                            m_bv = 1'b0; m_dc = 0; m_op = OP_NONE;
                        end
                    end
                endcase
                if (e_ack) begin m_bv = 1'b1; m_ba = pf_address; m_bd = pf_rdata; end
            end

            // L2 responder latency bookkeeping.
            if (rst_now || l2_resp || !strobe) age = 0;
            else age++;
            if (l2_resp) lat = $urandom_range(0, 3);

            // Traffic sources.
            if (rst_now) begin
                d_act = 1'b0; p_act = 1'b0;
            end else begin
                if (e_dresp) d_act = 1'b0;
                if (e_ack)   p_act = 1'b0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act  = 1'b1;
                d_wr   = $urandom_range(0, 1) == 1;
                d_addr = {12'h100 + 12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
                d_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!p_act && $urandom_range(0, 3) == 0) begin
                p_act  = 1'b1;
                p_addr = {12'h100 + 12'($urandom_range(0, 3)), 4'h0};
                p_data = {$urandom, $urandom, $urandom, $urandom};
            end

            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
